muldiv_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer that backs the HI/LO registers for MULTU/DIVU.
- Sits beside the single-cycle ALU in the execute stage; the ALU keeps the combinational AND/OR/ADD/SUB/SLT/SRL/ADDIU ops.
- Control starts an operation here, stalls on busy, and MFHI/MFLO read hi/lo.
- Internally iterates one 33-bit add/subtract plus shift per cycle (shift-add multiply, restoring divide).

---
 rtl/muldiv_seq.sv | 120 ++++++++++++
 tb/tb_muldiv_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle unsigned MULTU/DIVU sequencer backing HI/LO
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset (0 = reset)
//   start     request a new operation, sampled only in IDLE
//   op        0 = MULTU, 1 = DIVU, sampled with start
//   dataA     multiplicand / dividend, sampled with start
//   dataB     multiplier / divisor, sampled with start
//   busy      high while iterating (RUN)
//   done      one-cycle pulse when hi/lo become valid
//   hi        MULTU: product upper half; DIVU: remainder
//   lo        MULTU: product lower half; DIVU: quotient
//   div_zero  last accepted DIVU had a zero divisor
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic [WIDTH-1:0]   b_r;
    // One shared working register: {acc_hi, acc_lo} for MULTU, {rem, quo} for DIVU.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] sh;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // One iteration step: a single 33-bit add (multiply) or subtract (divide).
    always_comb begin
        sum      = '0;
        diff     = '0;
        sh       = acc << 1;
        acc_next = acc;
        if (!op_r) begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
            // Shift the 65-bit {carry, sum, acc_lo} right by one; carry lands in the MSB.
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            diff = {1'b0, sh[2*WIDTH-1:WIDTH]} - {1'b0, b_r};
            // Borrow clear means the divisor fits: keep the difference, set the quotient bit.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_next = sh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_r     <= 1'b0;
            b_r      <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        b_r      <= dataB;
                        div_zero <= 1'b0;
                        if (op && (dataB == '0)) begin
                            hi       <= dataA;
                            lo       <= '1;
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            // Both ops start from {0, dataA}: acc_lo = multiplicand, quo = dividend.
                            cnt   <= '0;
                            acc   <= {{WIDTH{1'b0}}, dataA};
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        lo    <= acc_next[WIDTH-1:0];
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking randomized bench for muldiv_seq
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dataA    (dataA),
        .dataB    (dataB),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference results from plain arithmetic.
    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo,
                         output logic e_dz, output int e_lat, output int e_busy);
        logic [63:0] p;
        if (!o) begin
            p = {32'd0, a} * {32'd0, b};
            e_hi = p[63:32]; e_lo = p[31:0]; e_dz = 1'b0; e_lat = 33; e_busy = 32;
        end else if (b == 32'd0) begin
            e_hi = a; e_lo = 32'hFFFF_FFFF; e_dz = 1'b1; e_lat = 1; e_busy = 0;
        end else begin
            e_hi = a % b; e_lo = a / b; e_dz = 1'b0; e_lat = 33; e_busy = 32;
        end
    endtask

    // Issue one op from IDLE; count cycles until done, then check results and pulse width.
    // With hold set, start stays high and operands are scrambled during RUN.
    task automatic do_op(input string tag, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          e_lat, e_busy, n, nb;
        model(o, a, b, e_hi, e_lo, e_dz, e_lat, e_busy);
        @(negedge clk);
        start = 1'b1; op = o; dataA = a; dataB = b;
        @(posedge clk);
        n = 0; nb = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            else begin dataA = $urandom; dataB = $urandom; op = ~op; end
            if (busy) nb++;
            if (done) begin n = i; break; end
        end
        check({tag, ".latency"}, 64'(n), 64'(e_lat));
        check({tag, ".busy_cycles"}, 64'(nb), 64'(e_busy));
        check({tag, ".hi"}, 64'(hi), 64'(e_hi));
        check({tag, ".lo"}, 64'(lo), 64'(e_lo));
        check({tag, ".div_zero"}, 64'(div_zero), 64'(e_dz));
        if (!hold) begin
            @(negedge clk);
            check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
            check({tag, ".hold_hi"}, 64'(hi), 64'(e_hi));
            check({tag, ".hold_lo"}, 64'(lo), 64'(e_lo));
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        ro;
        int          n;
        reset = 1'b0; start = 1'b0; op = 1'b0; dataA = '0; dataB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.hi", 64'(hi), 64'd0);
        check("rst.lo", 64'(lo), 64'd0);
        check("rst.div_zero", 64'(div_zero), 64'd0);
        reset = 1'b1;

        do_op("mul7x6", 1'b0, 32'd7, 32'd6, 1'b0);
        do_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mulmsb", 1'b0, 32'h8000_0000, 32'd2, 1'b0);
        do_op("div100_7", 1'b1, 32'd100, 32'd7, 1'b0);
        do_op("divmax_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("div5_0", 1'b1, 32'd5, 32'd0, 1'b0);
        do_op("mul3x3", 1'b0, 32'd3, 32'd3, 1'b0);

        // Protocol: start held high, operands scrambled mid-RUN.
        do_op("hold1", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        // Now in the DONE cycle with start still high; present the next op.
        op = 1'b1; dataA = 32'd1000; dataB = 32'd33;
        @(negedge clk);
        check("hold.idle_busy", 64'(busy), 64'd0);
        check("hold.idle_done", 64'(done), 64'd0);
        @(negedge clk);
        check("hold.accept_busy", 64'(busy), 64'd1);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin n = 1; break; end
        end
        check("hold2.done_seen", 64'(n), 64'd1);
        check("hold2.lo", 64'(lo), 64'd30);
        check("hold2.hi", 64'(hi), 64'd10);

        // Reset abort at RUN cycle 10.
        @(negedge clk);
        start = 1'b1; op = 1'b0; dataA = 32'd7; dataB = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("abort.no_done", 64'(n), 64'd0);
        do_op("div9_2", 1'b1, 32'd9, 32'd2, 1'b0);

        // Randomized ops against the arithmetic model.
        for (int k = 0; k < 30; k++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rnd%0d", k), ro, ra, rb, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
